// File: rtl/multi_freq_counter.sv
// multi_freq_counter
// Multi-channel gated frequency counter. Each asynchronous pulse input is
// synchronised and its rising edges are counted over a common gate window of
// GATE_CYCLES clocks. At each window end all channels are latched together,
// with a one-cycle valid strobe and per-channel saturation flags.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   freq        asynchronous pulse inputs, bit i = channel i
//   enable      measurement enable; low aborts a window and holds IDLE
//   continuous  1 = back-to-back windows, 0 = single-shot
//   start       single-shot trigger, only looked at in IDLE
//   frequency   latched edge counts, channel i at [i*WIDTH +: WIDTH]
//   overflow    latched per-channel saturation flag of the last window
//   valid       one-cycle strobe when frequency/overflow update
//   busy        high while a window is being measured
module multi_freq_counter #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int GATE_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       freq,
  input  logic                      enable,
  input  logic                      continuous,
  input  logic                      start,
  output logic [CHANNELS*WIDTH-1:0] frequency,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      valid,
  output logic                      busy
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Saturating increment of a channel count.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic inc);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + {{(WIDTH-1){1'b0}}, inc};
    end
  endfunction

  state_t state, next_state;

  logic [CHANNELS-1:0]             sync1, sync2, prev;
  logic [CHANNELS-1:0]             rise;
  logic [GW-1:0]                   gate;
  logic [CHANNELS-1:0][WIDTH-1:0]  count;
  logic [CHANNELS-1:0][WIDTH-1:0]  sat_count;
  logic [CHANNELS-1:0]             ovf;
  logic [CHANNELS-1:0]             ovf_next;
  logic                            window_end;
  logic                            run;

  assign rise = sync2 & ~prev;

  // Two-flop synchroniser plus previous-value register, running in all states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {CHANNELS{1'b0}};
      sync2 <= {CHANNELS{1'b0}};
      prev  <= {CHANNELS{1'b0}};
    end else begin
      sync1 <= freq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an enable drop wins over a coincident window end so an
  // aborted window never produces a result.
  always_comb begin
    next_state = state;
    run        = 1'b0;
    window_end = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (continuous || start)) begin
          next_state = MEASURE;
        end else begin
          next_state = IDLE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          next_state = IDLE;
        end else begin
          run        = 1'b1;
          window_end = (gate == GATE_LAST);
          if (window_end && !continuous) begin
            next_state = IDLE;
          end else begin
            next_state = MEASURE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Final per-channel result including the edge seen in the window-end cycle,
  // so back-to-back windows neither drop nor double-count an edge.
  always_comb begin
    sat_count = '0;
    ovf_next  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sat_count[i] = sat_inc(count[i], rise[i]);
      ovf_next[i]  = ovf[i] | ((count[i] == CNT_MAX) & rise[i]);
    end
  end

  // Gate and edge counters; held clear whenever no window is running and
  // restarted at every window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate  <= '0;
      count <= '0;
      ovf   <= '0;
    end else if (!run || window_end) begin
      gate  <= '0;
      count <= '0;
      ovf   <= '0;
    end else begin
      gate  <= gate + GW'(1);
      count <= sat_count;
      ovf   <= ovf_next;
    end
  end

  // Registered outputs: results latch only at a completed window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frequency <= '0;
      overflow  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state == MEASURE);
      if (window_end) begin
        frequency <= sat_count;
        overflow  <= ovf_next;
        valid     <= 1'b1;
      end else begin
        valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_freq_counter.sv
// Self-checking bench for multi_freq_counter with directed stimulus:
// continuous counting on four channels, saturation, single-shot, enable
// abort and asynchronous reset.
module tb_multi_freq_counter;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int G  = 1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   freq;
  logic            enable;
  logic            continuous;
  logic            start;
  logic [CH*W-1:0] frequency;
  logic [CH-1:0]   overflow;
  logic            valid;
  logic            busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int per [CH]  = '{0, 0, 0, 0};
  int phase     = 0;

  multi_freq_counter #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .GATE_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freq       (freq),
    .enable     (enable),
    .continuous (continuous),
    .start      (start),
    .frequency  (frequency),
    .overflow   (overflow),
    .valid      (valid),
    .busy       (busy)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // Pulse generator: channel i has period per[i] clocks, 50% duty; <2 = idle low.
  initial begin
    freq = '0;
    forever begin
      @(negedge clk);
      phase++;
      for (int i = 0; i < CH; i++) begin
        if (per[i] < 2) freq[i] = 1'b0;
        else            freq[i] = ((phase % per[i]) < (per[i] / 2));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] fch(input int i);
    return 32'(frequency[i*W +: W]);
  endfunction

  // Waits for valid, sampling 1 time unit after each rising edge; n = cycles waited.
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < budget);
    if (!valid) check({tag, "_timeout"}, 32'(valid), 32'd1);
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
  endtask

  int n;
  int nv;
  int f3a;

  initial begin
    rst = 1'b1; enable = 1'b0; continuous = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frequency", frequency, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Continuous mode, channel periods 10/20/40/80 clocks.
    per = '{10, 20, 40, 80};
    @(negedge clk);
    enable = 1'b1; continuous = 1'b1;
    wait_valid("cont_first", G + 20, n);
    wait_valid("cont_w2", G + 5, n);
    check("cont_period", n, G);
    check("cont_f0", fch(0), 32'd100);
    check("cont_f1", fch(1), 32'd50);
    check("cont_f2", fch(2), 32'd25);
    check("cont_ovf", 32'(overflow), 32'd0);
    f3a = fch(3);
    @(posedge clk);
    #1;
    check("valid_width", 32'(valid), 32'd0);
    check("cont_busy", 32'(busy), 32'd1);
    wait_valid("cont_w3", G + 5, n);
    check("cont_period2", n, G - 1);
    check("cont_f0_w3", fch(0), 32'd100);
    check("cont_f3_two_windows", f3a + fch(3), 32'd25);

    // Saturation: channel 1 toggling every clock gives 500 edges per window.
    per[1] = 2;
    wait_valid("sat_skip", G + 5, n);
    wait_valid("sat_w", G + 5, n);
    check("sat_f1", fch(1), 32'd255);
    check("sat_ovf", 32'(overflow), 32'b0010);
    check("sat_f0", fch(0), 32'd100);
    per[1] = 0;
    wait_valid("idle_skip", G + 5, n);
    wait_valid("idle_w", G + 5, n);
    check("idle_f1", fch(1), 32'd0);
    check("idle_ovf", 32'(overflow), 32'd0);

    // Abort to IDLE, then start with enable low must be ignored.
    @(negedge clk);
    enable = 1'b0; continuous = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    @(negedge clk) start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("start_dis_busy", 32'(busy), 32'd0);
    @(negedge clk) start = 1'b0;
    per[1] = 20;

    // Single-shot measurements.
    @(negedge clk);
    enable = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    check("ss_busy_rise", 32'(busy), 32'd1);
    @(negedge clk) start = 1'b0;
    wait_valid("ss1", G + 5, n);
    check("ss_latency", n, G);
    check("ss_busy_fall", 32'(busy), 32'd0);
    check("ss_f0", fch(0), 32'd100);
    check("ss_f1", fch(1), 32'd50);
    check("ss_f2", fch(2), 32'd25);
    count_valids(50, nv);
    check("ss_idle_valids", nv, 32'd0);
    check("ss_idle_busy", 32'(busy), 32'd0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk) start = 1'b0;
    wait_valid("ss2", G + 5, n);
    check("ss2_latency", n, G);
    check("ss2_f0", fch(0), 32'd100);

    // Enable dropped halfway through a continuous window.
    @(negedge clk) continuous = 1'b1;
    @(posedge clk);
    #1;
    check("drop_busy_on", 32'(busy), 32'd1);
    repeat (499) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    @(posedge clk);
    #1;
    check("drop_busy_off", 32'(busy), 32'd0);
    check("drop_valid", 32'(valid), 32'd0);
    count_valids(G + 100, nv);
    check("drop_no_valid", nv, 32'd0);
    check("drop_hold", 32'(frequency[3*W-1:0]), {8'd0, 8'd25, 8'd50, 8'd100});

    // Asynchronous reset in the middle of a window.
    @(negedge clk) enable = 1'b1;
    repeat (300) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_f0", fch(0), 32'd100);
    rst = 1'b1;
    #1;
    check("arst_frequency", frequency, 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
